collatz_batch_ctrl: RTL

- Upstream sequencer for the generated collatz core.
- Accepts a batch command (base, count) and runs the core once per n in [base, base+count-1].
- For each run it pulses the core's active-low reset, holds `start`, waits for `finish`, captures `ret0` and streams (n, steps) out over valid/ready.
- Tracks the maximum step count and its argument; flags runs that exceed a watchdog limit.

---
 rtl/collatz_batch_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/collatz_batch_ctrl.sv
// collatz_batch_ctrl: sequences a Collatz core over the values n in [base, base+count-1].
// For each n the core is held in reset, then started and watched by a watchdog.
// Each result is streamed out over valid/ready while the controller tracks the batch maximum.
module collatz_batch_ctrl #(
  parameter int unsigned W               = 32,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned CORE_RST_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 65536
) (
  input  logic             clk,
  input  logic             rst,
  // batch command
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_base,
  input  logic [CNT_W-1:0] cmd_count,
  // core interface
  output logic             core_rst_n,
  output logic             core_start,
  output logic [W-1:0]     core_n,
  input  logic             core_finish,
  input  logic [W-1:0]     core_ret,
  // result stream
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_n,
  output logic [W-1:0]     res_steps,
  output logic             res_timeout,
  // batch status
  output logic             batch_done,
  output logic [W-1:0]     max_steps,
  output logic [W-1:0]     max_n
);

  localparam int unsigned RST_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_RUN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [W-1:0]     cur_n;
  logic [CNT_W-1:0] remaining;
  logic [RST_W-1:0] rst_cnt;
  logic [TMR_W-1:0] timer;
  logic             have_max;

  // Batch sequencer: one run per n, with every output registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      core_rst_n  <= 1'b0;
      core_start  <= 1'b0;
      core_n      <= '0;
      res_valid   <= 1'b0;
      res_n       <= '0;
      res_steps   <= '0;
      res_timeout <= 1'b0;
      batch_done  <= 1'b0;
      max_steps   <= '0;
      max_n       <= '0;
      have_max    <= 1'b0;
      cur_n       <= '0;
      remaining   <= '0;
      rst_cnt     <= '0;
      timer       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready  <= 1'b1;
          core_rst_n <= 1'b0;
          core_start <= 1'b0;
          batch_done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cur_n     <= cmd_base;
            core_n    <= cmd_base;
            remaining <= cmd_count;
            max_steps <= '0;
            max_n     <= '0;
            have_max  <= 1'b0;
            cmd_ready <= 1'b0;
            rst_cnt   <= '0;
            if (cmd_count == '0) begin
              state      <= S_DONE;
              batch_done <= 1'b1;
            end else begin
              state <= S_CRST;
            end
          end
        end

        // Hold the core in reset with n already presented.
        S_CRST: begin
          core_rst_n <= 1'b0;
          core_start <= 1'b0;
          core_n     <= cur_n;
          if (rst_cnt == RST_W'(CORE_RST_CYCLES - 1)) begin
            state      <= S_RUN;
            timer      <= '0;
            core_rst_n <= 1'b1;
            core_start <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        // Wait for finish; the watchdog fires if the core takes too long.
        S_RUN: begin
          timer <= timer + TMR_W'(1);
          if (core_finish) begin
            res_n       <= cur_n;
            res_steps   <= core_ret;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            core_rst_n  <= 1'b0;
            core_start  <= 1'b0;
            state       <= S_EMIT;
            // Strict greater-than keeps the earliest n on ties.
            if (!have_max || (core_ret > max_steps)) begin
              max_steps <= core_ret;
              max_n     <= cur_n;
              have_max  <= 1'b1;
            end
          end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            res_n       <= cur_n;
            res_steps   <= '1;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            core_rst_n  <= 1'b0;
            core_start  <= 1'b0;
            state       <= S_EMIT;
          end
        end

        // Present the result; the core stays parked in reset until it is taken.
        S_EMIT: begin
          core_rst_n <= 1'b0;
          core_start <= 1'b0;
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state      <= S_DONE;
              batch_done <= 1'b1;
            end else begin
              cur_n   <= cur_n + W'(1);
              core_n  <= cur_n + W'(1);
              rst_cnt <= '0;
              state   <= S_CRST;
            end
          end
        end

        // One-cycle completion pulse, then accept commands again.
        S_DONE: begin
          batch_done <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
